// File: rtl/mem_stage_pkg.sv
// Shared RV32I types for the memory stage: opcodes, funct3 encodings, FSM states
// and the access-size decode used by both store masking and load extraction.
package mem_stage_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

    // Any funct3 that is not a byte or half encoding is treated as a word access.
    function automatic acc_size_t acc_size(input logic is_store, input logic [2:0] funct3);
        acc_size_t sz;
        sz = SZ_W;
        if (is_store) begin
            if (funct3 == sb)      sz = SZ_B;
            else if (funct3 == sh) sz = SZ_H;
        end else begin
            if (funct3 == lb || funct3 == lbu)      sz = SZ_B;
            else if (funct3 == lh || funct3 == lhu) sz = SZ_H;
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response bus between the memory stage (master) and the cache (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    rv32i_word   dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_mbe;
    rv32i_word   dmem_wdata;
    rv32i_word   dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load extraction: selects byte/half/word from a cache word and sign/zero-extends it.
// Purely combinational, no backpressure.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  rv32i_word  rdata,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output rv32i_word  data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sext   = !funct3[2];
        data   = rdata;
        case (acc_size(1'b0, funct3))
            SZ_B:    data = {{24{sext & byte_v[7]}}, byte_v};
            SZ_H:    data = {{16{sext & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues cache loads/stores, holds the pipe until dmem_resp, registers writeback.
// Latency: non-memory ops 1 cycle; memory ops accept cycle + WAIT cycles up to resp, wb the cycle after.
// Backpressure: mem_stall freezes upstream until the resp edge. MISALIGN_TRAP_EN enables misalign traps.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [6:0]   in_opcode,
    input  logic [2:0]   in_funct3,
    input  logic [4:0]   in_rd,
    input  logic         in_load_regfile,
    input  rv32i_word    in_pc,
    input  rv32i_word    in_alu_out,
    input  rv32i_word    in_rs2,
    output logic         mem_stall,
    mem_stage_if.master  dmem,
    output logic         wb_valid,
    output logic [4:0]   wb_rd,
    output logic         wb_load_regfile,
    output rv32i_word    wb_data,
    output rv32i_word    wb_pc,
    output logic         wb_misalign
);

    mem_state_t state_q, state_d;
    rv32i_word  addr_q, addr_d, pc_q, pc_d, wdata_q, wdata_d;
    logic [2:0] funct3_q, funct3_d;
    logic [4:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic [3:0] mbe_q, mbe_d;
    logic       load_regfile_q, load_regfile_d, rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic       wb_valid_q, wb_valid_d, wb_lrf_q, wb_lrf_d, wb_mis_q, wb_mis_d;
    rv32i_word  wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;

    logic       is_load, is_store;
    acc_size_t  sz;
    logic [1:0] a;
    logic [3:0] st_mbe;
    rv32i_word  st_wdata, load_data;

    assign is_load  = (in_opcode == op_load);
    assign is_store = (in_opcode == op_store);
    assign sz       = acc_size(is_store, in_funct3);
    assign a        = in_alu_out[1:0];

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
`endif

    mem_stage_load_align u_load_align (
        .rdata   (dmem.dmem_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .data    (load_data)
    );

    always_comb begin
        st_mbe   = 4'b1111;
        st_wdata = in_rs2;
        case (sz)
            SZ_B: begin
                st_mbe   = 4'b0001 << a;
                st_wdata = {4{in_rs2[7:0]}};
            end
            SZ_H: begin
                st_mbe   = 4'b0011 << {a[1], 1'b0};
                st_wdata = {2{in_rs2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        pc_d           = pc_q;
        wdata_d        = wdata_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        mbe_d          = mbe_q;
        load_regfile_d = load_regfile_q;
        rd_req_d       = rd_req_q;
        wr_req_d       = wr_req_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_lrf_d       = wb_lrf_q;
        wb_mis_d       = wb_mis_q;
        wb_data_d      = wb_data_q;
        wb_pc_d        = wb_pc_q;
        mem_stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!(is_load || is_store)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_lrf_d   = in_load_regfile;
                        wb_mis_d   = 1'b0;
                        wb_data_d  = in_alu_out;
                        wb_pc_d    = in_pc;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_lrf_d   = 1'b0;
                        wb_mis_d   = 1'b1;
                        wb_data_d  = in_alu_out;
                        wb_pc_d    = in_pc;
                    end
`endif
                    else begin
                        mem_stall      = 1'b1;
                        state_d        = WAIT;
                        addr_d         = in_alu_out;
                        pc_d           = in_pc;
                        funct3_d       = in_funct3;
                        rd_d           = in_rd;
                        load_regfile_d = in_load_regfile;
                        mbe_d          = is_load ? 4'b1111 : st_mbe;
                        wdata_d        = is_load ? in_rs2 : st_wdata;
                        rd_req_d       = is_load;
                        wr_req_d       = !is_load;
                    end
                end
            end
            WAIT: begin
                // Releasing the stall on the resp cycle lets the next instruction land in IDLE.
                mem_stall = !dmem.dmem_resp;
                if (dmem.dmem_resp) begin
                    state_d    = IDLE;
                    rd_req_d   = 1'b0;
                    wr_req_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_lrf_d   = rd_req_q & load_regfile_q;
                    wb_mis_d   = 1'b0;
                    wb_data_d  = rd_req_q ? load_data : addr_q;
                    wb_pc_d    = pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            pc_q           <= '0;
            wdata_q        <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            mbe_q          <= '0;
            load_regfile_q <= 1'b0;
            rd_req_q       <= 1'b0;
            wr_req_q       <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_lrf_q       <= 1'b0;
            wb_mis_q       <= 1'b0;
            wb_data_q      <= '0;
            wb_pc_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            pc_q           <= pc_d;
            wdata_q        <= wdata_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            mbe_q          <= mbe_d;
            load_regfile_q <= load_regfile_d;
            rd_req_q       <= rd_req_d;
            wr_req_q       <= wr_req_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_lrf_q       <= wb_lrf_d;
            wb_mis_q       <= wb_mis_d;
            wb_data_q      <= wb_data_d;
            wb_pc_q        <= wb_pc_d;
        end
    end

    assign dmem.dmem_address = {addr_q[31:2], 2'b00};
    assign dmem.dmem_read    = rd_req_q;
    assign dmem.dmem_write   = wr_req_q;
    assign dmem.dmem_mbe     = mbe_q;
    assign dmem.dmem_wdata   = wdata_q;

    assign wb_valid        = wb_valid_q;
    assign wb_rd           = wb_rd_q;
    assign wb_load_regfile = wb_lrf_q;
    assign wb_data         = wb_data_q;
    assign wb_pc           = wb_pc_q;
    assign wb_misalign     = wb_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized instruction stream against a transaction-level model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_load_regfile;
    logic [31:0] in_pc, in_alu_out, in_rs2;
    logic        mem_stall;
    logic        wb_valid, wb_load_regfile, wb_misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_pc;

    mem_stage_if dmem ();

    always #5 clk = ~clk;

    mem_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_opcode       (in_opcode),
        .in_funct3       (in_funct3),
        .in_rd           (in_rd),
        .in_load_regfile (in_load_regfile),
        .in_pc           (in_pc),
        .in_alu_out      (in_alu_out),
        .in_rs2          (in_rs2),
        .mem_stall       (mem_stall),
        .dmem            (dmem),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_load_regfile (wb_load_regfile),
        .wb_data         (wb_data),
        .wb_pc           (wb_pc),
        .wb_misalign     (wb_misalign)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Access width in bytes, from the RV32I funct3 rules.
    function automatic int size_of(input bit is_store, input logic [2:0] f3);
        if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int a, input logic [31:0] rdata);
        logic [31:0] v;
        int n;
        n = size_of(1'b0, f3);
        if (n == 1) begin
            v = (rdata >> (8 * a)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = (rdata >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_mbe(input bit is_store, input logic [2:0] f3, input int a);
        int n;
        if (!is_store) return 4'hF;
        n = size_of(1'b1, f3);
        if (n == 1) return 4'(1 << a);
        if (n == 2) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int n;
        n = size_of(1'b1, f3);
        if (n == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic bit exp_trap(input bit is_store, input logic [2:0] f3, input int a);
`ifdef MISALIGN_TRAP_EN
        int n;
        n = size_of(is_store, f3);
        return (n == 2 && (a % 2) != 0) || (n == 4 && a != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after the writeback edge.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic lrf, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int waits);
        bit is_ld, is_st, is_mem, trap;
        int a;
        is_ld  = (op == op_load);
        is_st  = (op == op_store);
        is_mem = is_ld || is_st;
        a      = int'(alu[1:0]);
        trap   = is_mem && exp_trap(is_st, f3, a);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_rd = rd;
        in_load_regfile = lrf; in_pc = pc; in_alu_out = alu; in_rs2 = rs2;
        dmem.dmem_resp = 1'b0;
        #1;
        check_eq("stall_accept", mem_stall, is_mem && !trap);
        @(posedge clk); #1;
        if (!is_mem || trap) begin
            check_eq("pt_wb_valid", wb_valid, 1'b1);
            check_eq("pt_wb_data", wb_data, alu);
            check_eq("pt_wb_pc", wb_pc, pc);
            check_eq("pt_wb_misalign", wb_misalign, trap);
            check_eq("pt_wb_lrf", wb_load_regfile, trap ? 1'b0 : lrf);
            if (!trap) check_eq("pt_wb_rd", wb_rd, rd);
            check_eq("pt_no_req", {dmem.dmem_read, dmem.dmem_write}, 2'b00);
        end else begin
            // Upstream content is irrelevant once accepted.
            in_alu_out = $urandom; in_rs2 = $urandom; in_funct3 = 3'($urandom);
            in_rd = 5'($urandom); in_pc = $urandom;
            check_eq("req_read", dmem.dmem_read, is_ld);
            check_eq("req_write", dmem.dmem_write, is_st);
            check_eq("req_addr", dmem.dmem_address, alu & 32'hFFFF_FFFC);
            check_eq("req_mbe", dmem.dmem_mbe, exp_mbe(is_st, f3, a));
            if (is_st) check_eq("req_wdata", dmem.dmem_wdata, exp_wdata(f3, rs2));
            check_eq("wait_wb_valid", wb_valid, 1'b0);
            for (int i = 0; i < waits; i++) begin
                dmem.dmem_rdata = $urandom;
                #1;
                check_eq("wait_stall", mem_stall, 1'b1);
                @(posedge clk); #1;
                check_eq("wait_wb_idle", wb_valid, 1'b0);
                check_eq("wait_addr_hold", dmem.dmem_address, alu & 32'hFFFF_FFFC);
                check_eq("wait_req_hold", {dmem.dmem_read, dmem.dmem_write}, {is_ld, is_st});
            end
            dmem.dmem_rdata = rdata;
            dmem.dmem_resp  = 1'b1;
            #1;
            check_eq("resp_stall", mem_stall, 1'b0);
            @(posedge clk); #1;
            dmem.dmem_resp = 1'b0;
            check_eq("mem_wb_valid", wb_valid, 1'b1);
            if (is_ld) check_eq("mem_wb_data", wb_data, exp_load(f3, a, rdata));
            check_eq("mem_wb_rd", wb_rd, rd);
            check_eq("mem_wb_pc", wb_pc, pc);
            check_eq("mem_wb_lrf", wb_load_regfile, is_ld ? lrf : 1'b0);
            check_eq("mem_wb_misalign", wb_misalign, 1'b0);
            check_eq("mem_req_drop", {dmem.dmem_read, dmem.dmem_write}, 2'b00);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check_eq("idle_wb_valid", wb_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_rd = '0;
        in_load_regfile = 1'b0; in_pc = '0; in_alu_out = '0; in_rs2 = '0;
        dmem.dmem_rdata = '0; dmem.dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_read", dmem.dmem_read, 1'b0);
        check_eq("rst_write", dmem.dmem_write, 1'b0);
        check_eq("rst_mbe", dmem.dmem_mbe, 4'h0);
        check_eq("rst_addr", dmem.dmem_address, 32'h0);
        check_eq("rst_wdata", dmem.dmem_wdata, 32'h0);
        check_eq("rst_wb_valid", wb_valid, 1'b0);
        check_eq("rst_wb_fields", {wb_rd, wb_load_regfile, wb_misalign}, 7'h0);
        check_eq("rst_wb_data", wb_data, 32'h0);
        check_eq("rst_wb_pc", wb_pc, 32'h0);
        rst = 1'b1;
        idle_cycles(1);

        run_op(op_reg, 3'd0, 5'd5, 1'b1, 32'h100, 32'h0000_1234, 32'h0, 32'h0, 0);
        run_op(op_load, 3'b000, 5'd7, 1'b1, 32'h104, 32'h1003, 32'h0, 32'h80FF_FF12, 3);
        run_op(op_load, 3'b100, 5'd8, 1'b1, 32'h108, 32'h1003, 32'h0, 32'h80FF_FF12, 1);
        run_op(op_store, 3'b001, 5'd9, 1'b1, 32'h10C, 32'h2002, 32'hDEAD_BEEF, 32'h0, 2);
        run_op(op_load, 3'b010, 5'd10, 1'b1, 32'h110, 32'h4000, 32'h0, 32'hCAFE_F00D, 0);
        run_op(op_load, 3'b010, 5'd11, 1'b1, 32'h114, 32'h4004, 32'h0, 32'h1234_5678, 0);
        run_op(op_load, 3'b010, 5'd12, 1'b1, 32'h118, 32'h3001, 32'h0, 32'hA5A5_5A5A, 1);
        idle_cycles(1);

        // Reset while a load is outstanding, then a stray response.
        in_valid = 1'b1; in_opcode = op_load; in_funct3 = 3'b010; in_alu_out = 32'h40;
        #1;
        @(posedge clk); #1;
        check_eq("rwait_read", dmem.dmem_read, 1'b1);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("rwait_read_drop", dmem.dmem_read, 1'b0);
        check_eq("rwait_wb_valid", wb_valid, 1'b0);
        check_eq("rwait_idle_stall", mem_stall, 1'b0);
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = $urandom;
        #1;
        check_eq("late_resp_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        dmem.dmem_resp = 1'b0;
        check_eq("late_resp_wb", wb_valid, 1'b0);
        check_eq("late_resp_req", {dmem.dmem_read, dmem.dmem_write}, 2'b00);

        for (int k = 0; k < 300; k++) begin
            logic [6:0] op;
            case ($urandom_range(0, 3))
                0:       op = op_reg;
                1:       op = op_imm;
                2:       op = op_load;
                default: op = op_store;
            endcase
            run_op(op, 3'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom,
                   $urandom, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Consumes the decoded control fields plus the ALU result from EX.
- Issues word-aligned load/store requests to the data cache with byte masks, and holds the pipeline until the cache responds.
- Returns sign/zero-extended load data, or passes the ALU result through, into a registered writeback bundle.

Parameters:
- none

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  EX/MEM holds a valid instruction
- in_opcode  in  7  rv32i_opcode of instruction
- in_funct3  in  3  load_funct3_t / store_funct3_t
- in_rd  in  5  destination register
- in_load_regfile  in  1  instruction writes rd
- in_pc  in  32  instruction PC
- in_alu_out  in  32  effective address, or result for non-memory ops
- in_rs2  in  32  store data
- mem_stall  out  1  freeze upstream stages and hold EX/MEM
- dmem_address  out  32  {addr[31:2],2'b00}
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_mbe  out  4  byte enable
- dmem_wdata  out  32  store data, lane-replicated
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse
- wb_valid  out  1  writeback bundle valid (one-cycle pulse per instruction)
- wb_rd  out  5
- wb_load_regfile  out  1
- wb_data  out  32  load result, or in_alu_out
- wb_pc  out  32
- wb_misalign  out  1  see Optional Feature

Behaviour:
- FSM states: IDLE, WAIT.
- Reset (rst=0 at a clock edge): state=IDLE, dmem_read/dmem_write=0, dmem_mbe=0, dmem_address/dmem_wdata=0, all wb_* outputs=0. Reset during WAIT abandons the request: dmem_read/write drop next cycle and no wb_valid is produced.
- IDLE, in_valid, opcode not load/store:
  - Registered passthrough: next cycle wb_valid=1, wb_data=in_alu_out.
  - mem_stall=0. Latency is 1 cycle.
- IDLE, in_valid, op_load or op_store:
  - mem_stall=1 combinationally.
  - At the edge: latch address, funct3, rd, pc, store data and mask; go to WAIT.
- WAIT:
  - dmem_read (load) or dmem_write (store) held at 1 from registers; address, mbe and wdata held stable.
  - mem_stall = !dmem_resp, so upstream advances on the resp edge.
  - On dmem_resp=1: next cycle request lines=0, state=IDLE, wb_valid=1 with extracted data.
  - Minimum memory-op latency: accept cycle + resp cycle, then wb.
- A new instruction can be accepted in the IDLE cycle that shows wb_valid (back-to-back).
- dmem_resp is ignored in IDLE.
- wb_valid is 0 in any cycle with no completion.
- Store byte masks and data (a = addr[1:0]):
  - sb: mbe = 4'b0001<<a; wdata = {4{rs2[7:0]}}.
  - sh: mbe = 4'b0011<<{a[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - sw: mbe = 4'b1111; wdata = rs2.
  - Loads: mbe = 4'b1111.
- Load extraction:
  - lb/lbu: byte a, sign- or zero-extended to 32.
  - lh/lhu: halfword a[1], sign- or zero-extended.
  - lw: whole word.
- Stores complete with wb_load_regfile=0 regardless of input.
- Undefined funct3 on a load/store behaves as the word variant.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are detected: half with addr[0]=1, or word with addr[1:0]!=0.
  - The access is never issued and the FSM stays IDLE; mem_stall=0.
  - Next cycle: wb_valid=1, wb_misalign=1, wb_load_regfile=0, wb_data=address.
- Undefined:
  - wb_misalign tied 0.
  - Misaligned accesses are issued and extracted using the address bits as above; low bits below the access size are ignored.

Decomposition:
- rv32i_types additions: enum mem_state_t {IDLE, WAIT}.
- Reuse load_funct3_t, store_funct3_t, rv32i_opcode and rv32i_word.
- One combinational sub-module, load_align: inputs rdata, funct3, addr[1:0]; output extended word. Reused later by forwarding logic.

Test Plan:
- ADD passthrough: in_valid, opcode=op_reg, alu_out=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, mem_stall never 1.
- lb, addr 0x1003, dmem_rdata=0x80FF_FF12, resp after 3 WAIT cycles:
  - mem_stall=1 for 4 cycles; dmem_address=0x1000, dmem_read=1.
  - wb_data=0xFFFF_FF80.
  - lbu at the same address -> 0x0000_0080.
- sh, addr 0x2002, rs2=0xDEAD_BEEF -> dmem_write=1, mbe=4'b1100, wdata=0xBEEF_BEEF; wb_load_regfile=0 after resp.
- Back-to-back lw, lw with resp in first WAIT cycle -> second request asserted 1 cycle after first wb_valid; two wb_valid pulses, no lost or duplicated request.
- rst=0 while in WAIT -> next cycle dmem_read=0, state IDLE, wb_valid=0; a late dmem_resp is ignored.
- With MISALIGN_TRAP_EN, lw at 0x3001 -> no dmem_read; next cycle wb_misalign=1, wb_data=0x3001. Without the macro -> dmem_address=0x3000, normal load.
